can_arbitration_rx: RTL
=======================

# can_arbitration_rx

Receive-side arbitration-field deserializer for the CAN decoder. It sits directly upstream of the identifier block. It consumes the destuffed serial bit stream on each sample point and assembles the base identifier, extended identifier, IDE and RTR. When the arbitration field is complete it raises `F_IDF`, so the identifier block can form the 29-bit `IDTFR`. It handles both base (11-bit) and extended (29-bit) frames, and supports abort and re-sync on a new start-of-frame.

## Interface
Parameters:
- `BASE_W`, 11: base identifier width.
- `EXT_W`, 18: extension identifier width.

Ports:
- `SP`  in  1  sample-point clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RX`  in  1  destuffed bus bit; 1 = recessive, 0 = dominant.
- `BIT_VALID`  in  1  `RX` is a data bit this cycle; 0 on stuff bits and gaps.
- `SOF`  in  1  one-cycle pulse on the cycle the SOF bit is sampled.
- `ABORT`  in  1  error/bus-off from error logic; drop the current field.
- `IDF`  out  11  base identifier, ID28..ID18, MSB first.
- `IDF_EX`  out  18  extended identifier, ID17..ID0; zero for base frames.
- `IDE`  out  1  identifier extension bit as received.
- `RTR`  out  1  remote request bit, taken from the base or extended position.
- `F_IDF`  out  1  level; arbitration field complete and outputs valid.
- `SRR_ERR`  out  1  level; extended frame received with a dominant SRR.

## Operation
- Reset: `reset`=1 at an `SP` edge forces IDLE. All outputs go to 0, and the bit counter goes to 0.
- States and transitions:
  - IDLE: on `SOF` go to BASE_ID. Clear `IDF`, `IDF_EX`, `IDE`, `RTR`, `F_IDF`, `SRR_ERR` and the counter.
  - BASE_ID: on each `BIT_VALID`, `IDF <= {IDF[9:0], RX}` and increment the counter. After the 11th bit, go to SRR_RTR.
  - SRR_RTR: on `BIT_VALID`, latch `RX` into an internal `srr_rtr`, then go to IDE_BIT.
  - IDE_BIT: on `BIT_VALID`, latch `IDE <= RX`.
    - If `RX`=0: `RTR <= srr_rtr`, `F_IDF <= 1`, go to DONE.
    - If `RX`=1: `SRR_ERR <= ~srr_rtr`, reset the counter, go to EXT_ID.
  - EXT_ID: on each `BIT_VALID`, `IDF_EX <= {IDF_EX[16:0], RX}`. After the 18th bit, go to RTR_EXT.
  - RTR_EXT: on `BIT_VALID`, `RTR <= RX`, `F_IDF <= 1`, go to DONE.
  - DONE: hold all outputs. On `SOF`, go to BASE_ID with a clear.
- Cycles with `BIT_VALID`=0 leave the state, counter and shift registers unchanged in every state.
- `SOF` has priority over `BIT_VALID` in the same cycle. The SOF bit is never shifted as data.
- `SOF` in any non-IDLE state, including mid-field, is a hard resync. Clear everything and go to BASE_ID.
- `ABORT`=1 in any state: go to IDLE and clear `F_IDF`.
  - Field registers keep their contents.
  - Priority is `reset` > `ABORT` > `SOF` > `BIT_VALID`.
- Counter: 5 bits, saturating is not required. Compare against `BASE_W-1` and `EXT_W-1` only.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `F_IDF` is visible after the `SP` edge that captures the last arbitration bit:
  - base frame: the 13th valid bit after `SOF`;
  - extended frame: the 32nd valid bit after `SOF`.
- `IDF`, `IDF_EX`, `IDE`, `RTR` and `SRR_ERR` are stable whenever `F_IDF`=1. They stay stable until the next `SOF`, `ABORT` or `reset`.
- `SRR_ERR` is set on the IDE edge of an extended frame. It is never set for base frames.
- Stuff-bit gaps of any length, including consecutive ones, do not change latency measured in valid bits.

## Structure
- Shared package `can_pkg`:
  - state encoding enum `arb_state_t` (IDLE, BASE_ID, SRR_RTR, IDE_BIT, EXT_ID, RTR_EXT, DONE);
  - constants `CAN_BASE_ID_W`=11, `CAN_EXT_ID_W`=18 and `CAN_ID_W`=29, shared with the identifier block.
- There is no sub-module. Shift registers and the counter are inline; a single FSM process plus datapath fits comfortably.

## Test plan
- Base frame: `SOF`, then bits `11001001010`, RTR=0, IDE=0, with no gaps. Required: `IDF`=0x64A, `IDE`=0, `RTR`=0, `IDF_EX`=0, and `F_IDF` high after the 13th valid bit.
- Extended frame: the same base bits, SRR=1, IDE=1, `111110001011000000`, RTR=1. Required: `IDF`=0x64A, `IDF_EX`=0x3E2C0, `IDE`=1, `RTR`=1, `SRR_ERR`=0, and `F_IDF` after the 32nd valid bit.
- Stuff gaps: repeat the extended frame with `BIT_VALID`=0 inserted after every 5th bit, and once twice in a row. Required: identical outputs, and `F_IDF` still after exactly 32 valid bits.
- Dominant SRR: an extended frame with SRR=0. Required: `SRR_ERR`=1 from the IDE edge onward, and the frame otherwise decodes correctly.
- Resync and abort:
  - `SOF` after 6 base bits, then a full base frame with ID 0x7FF. Required: `IDF`=0x7FF.
  - `ABORT` mid-EXT_ID. Required: `F_IDF` stays 0 and the FSM is in IDLE.
- Reset mid-field: assert `reset` during BASE_ID while `SOF` and `BIT_VALID` are also high. Required: all outputs are 0 on the next edge and the FSM is in IDLE.

Source files
------------

// File: rtl/can_pkg.sv
// Types and widths shared by the CAN receive arbitration path and the identifier block.
package can_pkg;

  localparam int CAN_BASE_ID_W = 11;
  localparam int CAN_EXT_ID_W  = 18;
  localparam int CAN_ID_W      = CAN_BASE_ID_W + CAN_EXT_ID_W;
  localparam int CAN_CNT_W     = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BASE_ID = 3'd1,
    SRR_RTR = 3'd2,
    IDE_BIT = 3'd3,
    EXT_ID  = 3'd4,
    RTR_EXT = 3'd5,
    DONE    = 3'd6
  } arb_state_t;

endpackage

// File: rtl/can_arbitration_rx.sv
// Deserializes the CAN arbitration field (base/extended ID, SRR, IDE, RTR) from the
// destuffed bit stream and flags completion with F_IDF.
module can_arbitration_rx
  import can_pkg::*;
#(
  parameter int BASE_W = CAN_BASE_ID_W,
  parameter int EXT_W  = CAN_EXT_ID_W
) (
  input  logic              SP,
  input  logic              reset,
  input  logic              RX,
  input  logic              BIT_VALID,
  input  logic              SOF,
  input  logic              ABORT,
  output logic [BASE_W-1:0] IDF,
  output logic [EXT_W-1:0]  IDF_EX,
  output logic              IDE,
  output logic              RTR,
  output logic              F_IDF,
  output logic              SRR_ERR
);

  arb_state_t           state_reg, state_next;
  logic [CAN_CNT_W-1:0] cnt_reg, cnt_next;
  logic [BASE_W-1:0]    idf_reg, idf_next;
  logic [EXT_W-1:0]     idf_ex_reg, idf_ex_next;
  logic                 ide_reg, ide_next;
  logic                 rtr_reg, rtr_next;
  logic                 f_idf_reg, f_idf_next;
  logic                 srr_err_reg, srr_err_next;
  logic                 srr_rtr_reg, srr_rtr_next;

  always_ff @(posedge SP) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idf_reg     <= '0;
      idf_ex_reg  <= '0;
      ide_reg     <= 1'b0;
      rtr_reg     <= 1'b0;
      f_idf_reg   <= 1'b0;
      srr_err_reg <= 1'b0;
      srr_rtr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idf_reg     <= idf_next;
      idf_ex_reg  <= idf_ex_next;
      ide_reg     <= ide_next;
      rtr_reg     <= rtr_next;
      f_idf_reg   <= f_idf_next;
      srr_err_reg <= srr_err_next;
      srr_rtr_reg <= srr_rtr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idf_next     = idf_reg;
    idf_ex_next  = idf_ex_reg;
    ide_next     = ide_reg;
    rtr_next     = rtr_reg;
    f_idf_next   = f_idf_reg;
    srr_err_next = srr_err_reg;
    srr_rtr_next = srr_rtr_reg;

    // Abort only drops the completion flag; captured fields stay for diagnostics.
    if (ABORT) begin
      state_next = IDLE;
      f_idf_next = 1'b0;
    end else if (SOF) begin
      // SOF from any state restarts the field; the SOF bit itself is not data.
      state_next   = BASE_ID;
      cnt_next     = '0;
      idf_next     = '0;
      idf_ex_next  = '0;
      ide_next     = 1'b0;
      rtr_next     = 1'b0;
      f_idf_next   = 1'b0;
      srr_err_next = 1'b0;
      srr_rtr_next = 1'b0;
    end else if (BIT_VALID) begin
      case (state_reg)
        BASE_ID: begin
          idf_next = {idf_reg[BASE_W-2:0], RX};
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CAN_CNT_W'(BASE_W - 1)) state_next = SRR_RTR;
        end
        SRR_RTR: begin
          srr_rtr_next = RX;
          state_next   = IDE_BIT;
        end
        IDE_BIT: begin
          ide_next = RX;
          if (!RX) begin
            rtr_next   = srr_rtr_reg;
            f_idf_next = 1'b1;
            state_next = DONE;
          end else begin
            // In an extended frame the bit before IDE is SRR and must be recessive.
            srr_err_next = ~srr_rtr_reg;
            cnt_next     = '0;
            state_next   = EXT_ID;
          end
        end
        EXT_ID: begin
          idf_ex_next = {idf_ex_reg[EXT_W-2:0], RX};
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == CAN_CNT_W'(EXT_W - 1)) state_next = RTR_EXT;
        end
        RTR_EXT: begin
          rtr_next   = RX;
          f_idf_next = 1'b1;
          state_next = DONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign IDF     = idf_reg;
  assign IDF_EX  = idf_ex_reg;
  assign IDE     = ide_reg;
  assign RTR     = rtr_reg;
  assign F_IDF   = f_idf_reg;
  assign SRR_ERR = srr_err_reg;

endmodule
